onehot_scan_decoder: RTL and testbench

Parametrised, registered binary-to-one-hot decoder with a built-in scan sequencer. In direct mode it decodes a SEL_W-bit select into a 2^SEL_W one-hot word. In scan mode it steps the active output round-robin at a programmable rate, for example to drive digit enables of a multiplexed 7-segment display. It sits between the control logic and the board-level enable/select lines.

---
 rtl/onehot_scan_decoder_if.sv | 40 ++++
 rtl/onehot_scan_decoder.sv | 111 +++++++++++
 tb/tb_onehot_scan_decoder.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/onehot_scan_decoder_if.sv
// ----------------------------------------------------------------------------
// onehot_scan_decoder_if
//   Bundles the control inputs and registered outputs of onehot_scan_decoder.
//   master : the controller side (drives en/mode/sel/load/period).
//   slave  : the decoder side (drives dout/idx/wrap).
// Signals
//   en     1      outputs active / sequencer running
//   mode   1      0 = direct decode, 1 = scan
//   sel    SEL_W  direct select, or start index on load
//   load   1      scan-mode reload of idx from sel
//   period DIV_W  scan dwell per index minus one
//   dout   N_OUT  registered one-hot output
//   idx    SEL_W  registered active index
//   wrap   1      one-cycle pulse on scan rollover to index 0
// ----------------------------------------------------------------------------
interface onehot_scan_decoder_if #(
  parameter int SEL_W = 3,
  parameter int DIV_W = 16
);
  localparam int N_OUT = 1 << SEL_W;

  logic             en;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic             load;
  logic [DIV_W-1:0] period;
  logic [N_OUT-1:0] dout;
  logic [SEL_W-1:0] idx;
  logic             wrap;

  modport master (
    output en, mode, sel, load, period,
    input  dout, idx, wrap
  );

  modport slave (
    input  en, mode, sel, load, period,
    output dout, idx, wrap
  );
endinterface

// File: rtl/onehot_scan_decoder.sv
// ----------------------------------------------------------------------------
// onehot_scan_decoder
//   Registered binary-to-one-hot decoder with a round-robin scan sequencer.
//   Direct mode decodes sel each cycle; scan mode steps idx every period+1
//   cycles (e.g. digit enables of a multiplexed display).
// Ports
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of onehot_scan_decoder_if (en, mode, sel, load,
//          period in; dout, idx, wrap out)
// Parameters
//   SEL_W       select width, N_OUT = 2**SEL_W outputs
//   DIV_W       prescaler width
//   ACTIVE_LOW  1 inverts every dout bit (idx and wrap stay active-high)
// ----------------------------------------------------------------------------
module onehot_scan_decoder #(
  parameter int SEL_W      = 3,
  parameter int DIV_W      = 16,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  onehot_scan_decoder_if.slave  bus
);

  localparam int               N_OUT    = 1 << SEL_W;
  localparam logic [N_OUT-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {N_OUT{1'b1}} : {N_OUT{1'b0}};
  localparam logic [SEL_W-1:0] IDX_MAX  = {SEL_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [SEL_W-1:0] r_idx,   w_idx_nxt;
  logic [DIV_W-1:0] r_cnt,   w_cnt_nxt;
  logic             r_wrap,  w_wrap_nxt;
  logic [N_OUT-1:0] r_dout,  w_dout_nxt;

  // Next-state and datapath. The operating state for this edge is taken from
  // en/mode directly; r_state only remembers what the previous edge did so a
  // fresh entry into scan can restart the dwell.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    w_state_nxt = ST_IDLE;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_wrap_nxt  = 1'b0;
    w_dout_nxt  = INACTIVE;

    if (bus.en) begin
      w_state_nxt = bus.mode ? ST_SCAN : ST_DIRECT;
    end

    case (w_state_nxt)
      ST_DIRECT: begin
        w_idx_nxt = bus.sel;
        w_cnt_nxt = '0;
      end
      ST_SCAN: begin
        if (bus.load) begin
          // Reload beats a coincident terminal count.
          w_idx_nxt = bus.sel;
          w_cnt_nxt = '0;
        end else if (r_state != ST_SCAN) begin
          // Fresh entry: keep idx, start a full dwell.
          w_cnt_nxt = '0;
        end else if (r_cnt == bus.period) begin
          w_cnt_nxt  = '0;
          w_idx_nxt  = r_idx + 1'b1;
          w_wrap_nxt = (r_idx == IDX_MAX);
        end else begin
          // A period lowered below cnt is missed until cnt rolls over.
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: ;  // idle: idx and cnt hold, outputs inactive
    endcase

    // dout is decoded from the index being registered on this same edge.
    if (w_state_nxt != ST_IDLE) begin
      w_dout_nxt = (N_OUT'(1) << w_idx_nxt) ^ INACTIVE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_wrap  <= 1'b0;
      r_dout  <= INACTIVE;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wrap  <= w_wrap_nxt;
      r_dout  <= w_dout_nxt;
    end
  end

  assign bus.dout = r_dout;
  assign bus.idx  = r_idx;
  assign bus.wrap = r_wrap;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// ----------------------------------------------------------------------------
// tb_onehot_scan_decoder
//   Two decoders: A (SEL_W=3, DIV_W=16, active-high) and B (SEL_W=2, DIV_W=4,
//   active-low) share the same stimulus. Directed scenarios check fixed
//   values; every cycle both outputs are also compared with a behavioural
//   model that tracks index, dwell counter and wrap as plain integers.
// ----------------------------------------------------------------------------
module tb_onehot_scan_decoder;

  logic clk;
  logic rst_n;

  onehot_scan_decoder_if #(.SEL_W(3), .DIV_W(16)) bus_a ();
  onehot_scan_decoder_if #(.SEL_W(2), .DIV_W(4))  bus_b ();

  onehot_scan_decoder #(.SEL_W(3), .DIV_W(16), .ACTIVE_LOW(0)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  onehot_scan_decoder #(.SEL_W(2), .DIV_W(4), .ACTIVE_LOW(1)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int idx;        // active index
    int cnt;        // cycles spent at this index (prescaler)
    bit wrap;
    bit scan_prev;  // previous edge was a scan edge
    bit act;        // previous edge had en=1
  } mdl_t;

  mdl_t ma, mb;

  task automatic mdl_step(inout mdl_t m, input int n, input int cmod,
                          input bit en, input bit mode, input bit load,
                          input int sel, input int period);
    m.wrap = 1'b0;
    if (!en) begin
      m.act       = 1'b0;
      m.scan_prev = 1'b0;
    end else if (!mode) begin
      m.act       = 1'b1;
      m.idx       = sel;
      m.cnt       = 0;
      m.scan_prev = 1'b0;
    end else begin
      m.act = 1'b1;
      if (load) begin
        m.idx = sel;
        m.cnt = 0;
      end else if (!m.scan_prev) begin
        m.cnt = 0;
      end else if (m.cnt == period) begin
        m.cnt  = 0;
        m.wrap = (m.idx == n - 1);
        m.idx  = (m.idx + 1) % n;
      end else begin
        m.cnt = (m.cnt + 1) % cmod;
      end
      m.scan_prev = 1'b1;
    end
  endtask

  function automatic int exp_dout(input mdl_t m, input int n, input bit active_low);
    int v;
    v = m.act ? (1 << m.idx) : 0;
    if (active_low) v = v ^ ((1 << n) - 1);
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit en, input bit mode, input bit load,
                       input int sel, input int period);
    bus_a.en     = en;
    bus_a.mode   = mode;
    bus_a.load   = load;
    bus_a.sel    = 3'(sel);
    bus_a.period = 16'(period);
    bus_b.en     = en;
    bus_b.mode   = mode;
    bus_b.load   = load;
    bus_b.sel    = 2'(sel);
    bus_b.period = 4'(period);
  endtask

  // One clock: advance the model on the edge, compare 1 time unit later.
  task automatic tick();
    @(posedge clk);
    mdl_step(ma, 8, 65536, bus_a.en, bus_a.mode, bus_a.load, int'(bus_a.sel), int'(bus_a.period));
    mdl_step(mb, 4, 16,    bus_b.en, bus_b.mode, bus_b.load, int'(bus_b.sel), int'(bus_b.period));
    #1;
    check("mdl_a_dout", 32'(bus_a.dout), 32'(exp_dout(ma, 8, 1'b0)));
    check("mdl_a_idx",  32'(bus_a.idx),  32'(ma.idx));
    check("mdl_a_wrap", 32'(bus_a.wrap), 32'(ma.wrap));
    check("mdl_b_dout", 32'(bus_b.dout), 32'(exp_dout(mb, 4, 1'b1)));
    check("mdl_b_idx",  32'(bus_b.idx),  32'(mb.idx));
    check("mdl_b_wrap", 32'(bus_b.wrap), 32'(mb.wrap));
  endtask

  task automatic mdl_reset();
    ma = '{default: 0};
    mb = '{default: 0};
  endtask

  logic [7:0] exp_dir [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur_period;
    bit r_en, r_mode, r_load;
    int r_sel;

    // ---------------- reset ----------------
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 0, 0);
    mdl_reset();
    #12;
    check("rst_a_dout", 32'(bus_a.dout), 32'h00);
    check("rst_a_idx",  32'(bus_a.idx),  32'h0);
    check("rst_a_wrap", 32'(bus_a.wrap), 32'h0);
    check("rst_b_dout", 32'(bus_b.dout), 32'hF);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- direct sweep ----------------
    for (int s = 0; s < 8; s++) begin
      drive(1'b1, 1'b0, 1'b0, s, 0);
      tick();
      check("dir_a_dout", 32'(bus_a.dout), 32'(exp_dir[s]));
      check("dir_a_idx",  32'(bus_a.idx),  32'(s));
      if (s == 2) check("dir_b_sel2", 32'(bus_b.dout), 32'b1011);
    end
    drive(1'b0, 1'b0, 1'b0, 7, 0);
    tick();
    check("dir_a_en0", 32'(bus_a.dout), 32'h00);
    check("dir_b_en0", 32'(bus_b.dout), 32'hF);

    // ---------------- scan, period=2, entry from idx 0 ----------------
    drive(1'b1, 1'b0, 1'b0, 0, 2);
    tick();
    drive(1'b1, 1'b1, 1'b0, 0, 2);
    tick();
    check("scan2_entry_idx", 32'(bus_a.idx), 32'd0);
    for (int k = 1; k <= 24; k++) begin
      tick();
      check("scan2_idx",  32'(bus_a.idx),  32'((k / 3) % 8));
      check("scan2_wrap", 32'(bus_a.wrap), 32'(k == 24));
    end

    // ---------------- scan, period=0, with load ----------------
    drive(1'b1, 1'b1, 1'b1, 6, 0);
    tick();
    check("load_idx6",  32'(bus_a.idx),  32'd6);
    check("load_dout6", 32'(bus_a.dout), 32'h40);
    drive(1'b1, 1'b1, 1'b0, 6, 0);
    tick();
    check("p0_idx7",  32'(bus_a.idx),  32'd7);
    check("p0_wrap7", 32'(bus_a.wrap), 32'd0);
    tick();
    check("p0_idx0",  32'(bus_a.idx),  32'd0);
    check("p0_wrap0", 32'(bus_a.wrap), 32'd1);
    check("p0_dout0", 32'(bus_a.dout), 32'h01);
    tick();
    check("p0_wrap_end", 32'(bus_a.wrap), 32'd0);

    // ---------------- load at terminal count, then en toggle ----------------
    drive(1'b1, 1'b1, 1'b1, 1, 2);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1, 2);
    tick();
    tick();
    check("tc_hold_idx1", 32'(bus_a.idx), 32'd1);
    drive(1'b1, 1'b1, 1'b1, 5, 2);   // counter is at terminal on this edge
    tick();
    check("tc_load_idx5", 32'(bus_a.idx), 32'd5);
    drive(1'b1, 1'b1, 1'b0, 5, 2);
    tick();
    tick();
    check("tc_dwell_idx5", 32'(bus_a.idx), 32'd5);
    tick();
    check("tc_adv_idx6", 32'(bus_a.idx), 32'd6);
    tick();
    drive(1'b0, 1'b1, 1'b0, 5, 2);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("en0_dout", 32'(bus_a.dout), 32'h00);
      check("en0_idx",  32'(bus_a.idx),  32'd6);
    end
    drive(1'b1, 1'b1, 1'b0, 5, 2);
    tick();
    check("resume_dout", 32'(bus_a.dout), 32'h40);
    tick();
    tick();
    check("resume_dwell_idx6", 32'(bus_a.idx), 32'd6);
    tick();
    check("resume_adv_idx7", 32'(bus_a.idx), 32'd7);

    // ---------------- asynchronous reset mid-scan at idx 5 ----------------
    drive(1'b1, 1'b1, 1'b1, 5, 3);
    tick();
    drive(1'b1, 1'b1, 1'b0, 5, 3);
    tick();
    check("pre_rst_idx5", 32'(bus_a.idx), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    mdl_reset();
    check("arst_a_dout", 32'(bus_a.dout), 32'h00);
    check("arst_a_idx",  32'(bus_a.idx),  32'd0);
    check("arst_a_wrap", 32'(bus_a.wrap), 32'd0);
    check("arst_b_dout", 32'(bus_b.dout), 32'hF);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- randomized phase ----------------
    cur_period = 1;
    for (int c = 0; c < 3000; c++) begin
      r_en   = ($urandom_range(0, 99) < 90);
      r_mode = ($urandom_range(0, 3) != 0);
      r_load = ($urandom_range(0, 15) == 0);
      r_sel  = int'($urandom_range(0, 7));
      // period only changes while idle or together with load
      if (!r_en || r_load) cur_period = int'($urandom_range(0, 3));
      drive(r_en, r_mode, r_load, r_sel, cur_period);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
